// File: rtl/pixel_stream_framer.sv
// pixel_stream_framer: pops FIFO pixels, tags x/y/sof/eol/eof for one frame, buffers 2 beats
module pixel_stream_framer #(
    parameter int DATA_W = 24,
    parameter int H_W    = 12,
    parameter int V_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [H_W-1:0]    cfg_h_active,
    input  logic [V_W-1:0]    cfg_v_active,
    input  logic              frame_start,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_vld,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [H_W-1:0]    m_x,
    output logic [V_W-1:0]    m_y,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_err
);
    localparam int E_W = DATA_W + H_W + V_W + 3;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
    logic [1:0]     state_q, state_d, cnt_q, cnt_d, cnt_p;
    logic [H_W-1:0] h_q, h_d, x_q, x_d;
    logic [V_W-1:0] v_q, v_d, y_q, y_d;
    logic [E_W-1:0] e0_q, e0_d, e1_q, e1_d, beat;
    logic           done_q, done_d, err_q, err_d, push, pull, last_x, last_y;
    assign fifo_rd_en = (state_q == RUN) && (cnt_q != 2'd2);
    assign push       = fifo_rd_vld & fifo_rd_en;
    assign m_valid    = cnt_q != 2'd0;
    assign pull       = m_valid & m_ready;
    assign last_x     = x_q == h_q - H_W'(1);
    assign last_y     = y_q == v_q - V_W'(1);
    assign beat       = {fifo_rd_data, x_q, y_q, x_q == '0 && y_q == '0, last_x, last_x && last_y};
    assign {m_data, m_x, m_y, m_sof, m_eol, m_eof} = e0_q;
    assign busy       = state_q != IDLE;
    assign frame_done = done_q;
    assign cfg_err    = err_q;
    always_comb begin
        cnt_p   = cnt_q - {1'b0, pull};
        cnt_d   = cnt_p + {1'b0, push};
        e0_d    = (push && cnt_p == 2'd0) ? beat : pull ? e1_q : e0_q;
        e1_d    = (push && cnt_p != 2'd0) ? beat : e1_q;
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (frame_start) begin
                h_d = cfg_h_active;
                v_d = cfg_v_active;
                if (cfg_h_active == '0 || cfg_v_active == '0) err_d = 1'b1;
                else begin
                    state_d = RUN;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            RUN: if (push) begin
                x_d = last_x ? '0 : x_q + H_W'(1);
                y_d = !last_x ? y_q : last_y ? '0 : y_q + V_W'(1);
                if (last_x && last_y) state_d = DRAIN;
            end
            DRAIN: if (cnt_d == 2'd0) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            e0_q    <= '0;
            e1_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            v_q     <= v_d;
            x_q     <= x_d;
            y_q     <= y_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_pixel_stream_framer.sv
// tb_pixel_stream_framer: table-driven frames plus random frames against a coordinate model
module tb_pixel_stream_framer;
    localparam int DW = 24, HW = 12, VW = 12;
    logic clk = 1'b0, rst = 1'b1;
    logic [HW-1:0] cfg_h_active = '0;
    logic [VW-1:0] cfg_v_active = '0;
    logic frame_start = 1'b0, fifo_rd_vld = 1'b0, m_ready = 1'b0;
    logic [DW-1:0] fifo_rd_data = '0;
    logic fifo_rd_en, m_valid, m_sof, m_eol, m_eof, busy, frame_done, cfg_err;
    logic [DW-1:0] m_data;
    logic [HW-1:0] m_x;
    logic [VW-1:0] m_y;
    int n_chk = 0, n_fail = 0;
    logic [DW-1:0] src[$];

    typedef struct {
        int h; int v; int vm; int rm; int restart; int seed;
        bit exp_err; int exp_beats;
    } vec_t;

    pixel_stream_framer dut (
        .clk(clk), .rst(rst), .cfg_h_active(cfg_h_active), .cfg_v_active(cfg_v_active),
        .frame_start(frame_start), .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld),
        .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_x(m_x), .m_y(m_y), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [55:0] all_outs();
        return {fifo_rd_en, m_valid, m_data, m_x, m_y, m_sof, m_eol, m_eof, busy, frame_done, cfg_err};
    endfunction

    // Drives one frame from negedge to negedge; expected beat i is pixel i at (i%H, i/H).
    task automatic run_frame(input vec_t t);
        int c = 0, beats = 0, pops = 0, dones = 0, errs = 0, rden = 0, bsy = 0;
        int first = -1, last = -1, limit, n;
        bit done_due = 0, stalled = 0;
        logic [50:0] head, prev_head, exp_b;
        n = t.h * t.v;
        limit = 60 + 12 * n;
        src.delete();
        for (int i = 0; i < n + 2; i++) src.push_back(DW'(t.seed + i));
        while (c < limit) begin
            frame_start  = (c == 0) || (t.restart != 0 && c == t.restart);
            cfg_h_active = (c == 0) ? HW'(t.h) : HW'(1);
            cfg_v_active = (c == 0) ? VW'(t.v) : VW'(1);
            fifo_rd_vld  = src.size() != 0 &&
                           (t.vm == 0 || (t.vm == 1 && c % 2 == 1) || (t.vm == 2 && $urandom_range(0, 3) != 0));
            if (src.size() != 0) fifo_rd_data = src[0];
            case (t.rm)
                0: m_ready = 1'b1;
                1: m_ready = (c % 2 == 0);
                2: m_ready = 1'($urandom_range(0, 1));
                default: m_ready = !(c >= 2 && c <= 6);
            endcase
            #1;
            head = {m_data, m_x, m_y, m_sof, m_eol, m_eof};
            if (stalled) check("hold", {m_valid, head}, {1'b1, prev_head});
            if (done_due) begin
                check("frame_done_timing", {frame_done, busy}, 2'b10);
                done_due = 0;
                limit = c + 3;
            end
            dones += int'(frame_done);
            errs  += int'(cfg_err);
            rden  += int'(fifo_rd_en);
            bsy   += int'(busy);
            if (m_valid && m_ready) begin
                exp_b = {DW'(t.seed + beats), HW'(beats % t.h), VW'(beats / t.h),
                         beats == 0, beats % t.h == t.h - 1, beats == n - 1};
                check("beat", head, exp_b);
                if (beats == n - 1) done_due = 1;
                if (first < 0) first = c;
                last = c;
                beats++;
            end
            stalled   = m_valid && !m_ready;
            prev_head = head;
            if (fifo_rd_vld && fifo_rd_en) begin
                void'(src.pop_front());
                pops++;
            end
            c++;
            @(negedge clk);
        end
        frame_start = 1'b0;
        fifo_rd_vld = 1'b0;
        check("beat_count", beats, t.exp_beats);
        check("pop_count", pops, t.exp_beats);
        check("frame_done_count", dones, t.exp_err ? 0 : 1);
        check("cfg_err_count", errs, t.exp_err ? 1 : 0);
        if (t.exp_err) check("err_quiet", {bsy, rden}, 0);
        if (!t.exp_err && t.vm == 0 && t.rm == 0) begin
            check("rd_en_cycles", rden, n);
            check("throughput", last - first, n - 1);
        end
    endtask

    vec_t vecs[8];
    vec_t rv;
    int beats;

    initial begin
        vecs[0] = '{4, 2, 0, 0, 0, 0, 1'b0, 8};
        vecs[1] = '{4, 2, 0, 3, 0, 16, 1'b0, 8};
        vecs[2] = '{4, 2, 1, 0, 0, 32, 1'b0, 8};
        vecs[3] = '{0, 2, 0, 0, 0, 48, 1'b1, 0};
        vecs[4] = '{3, 0, 0, 0, 0, 64, 1'b1, 0};
        vecs[5] = '{1, 1, 0, 0, 0, 'hABCDEF, 1'b0, 1};
        vecs[6] = '{4, 2, 0, 0, 3, 80, 1'b0, 8};
        vecs[7] = '{1, 3, 1, 1, 0, 96, 1'b0, 3};
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) run_frame(vecs[i]);
        for (int i = 0; i < 8; i++) begin
            rv.h = $urandom_range(1, 5);
            rv.v = $urandom_range(1, 4);
            rv.vm = 2;
            rv.rm = 2;
            rv.restart = 0;
            rv.seed = $urandom_range(0, 'hFFFFFF);
            rv.exp_err = 1'b0;
            rv.exp_beats = rv.h * rv.v;
            run_frame(rv);
        end
        // Reset in the middle of a frame, after pixel 5 has left the block.
        src.delete();
        for (int i = 0; i < 10; i++) src.push_back(DW'(100 + i));
        beats = 0;
        for (int c = 0; c < 40 && beats < 5; c++) begin
            frame_start  = (c == 0);
            cfg_h_active = HW'(4);
            cfg_v_active = VW'(2);
            fifo_rd_vld  = src.size() != 0;
            if (src.size() != 0) fifo_rd_data = src[0];
            m_ready = 1'b1;
            #1;
            if (m_valid) beats++;
            if (fifo_rd_vld && fifo_rd_en) void'(src.pop_front());
            @(negedge clk);
        end
        frame_start = 1'b0;
        check("rst_reached", beats, 5);
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_frame_reset", all_outs(), 0);
        rst = 1'b0;
        fifo_rd_vld = 1'b0;
        @(negedge clk);
        check("idle_after_reset", all_outs(), 0);
        run_frame('{4, 2, 0, 0, 0, 200, 1'b0, 8});
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_stream_framer.md
Name: pixel_stream_framer

Overview:
- Sits directly downstream of the 2048x24 prefetch sync FIFO in the image filter path.
- Pops 24-bit pixels through the FIFO's rd_data / rd_vld / rd_en interface.
- Tags each pixel with x/y coordinates and SOF/EOL/EOF markers for one configured frame.
- Delivers tagged pixels to the filter pipeline over a valid/ready stream, buffered by an internal 2-entry output buffer.

Parameters:
- DATA_W, 24, pixel width; matches the FIFO read width.
- H_W, 12, width of the horizontal size and x counter.
- V_W, 12, width of the vertical size and y counter.

Ports:
- clk  in  1  single clock, shared with the FIFO rd_clk.
- rst  in  1  synchronous, active-high reset.
- cfg_h_active  in  H_W  pixels per line; sampled at frame start.
- cfg_v_active  in  V_W  lines per frame; sampled at frame start.
- frame_start  in  1  one-cycle pulse that arms one frame.
- fifo_rd_data  in  DATA_W  FIFO head data.
- fifo_rd_vld  in  1  FIFO head valid.
- fifo_rd_en  out  1  pop request / ready to the FIFO.
- m_data  out  DATA_W  output pixel.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream ready.
- m_x  out  H_W  x coordinate of the output pixel.
- m_y  out  V_W  y coordinate of the output pixel.
- m_sof  out  1  first pixel of the frame.
- m_eol  out  1  last pixel of a line.
- m_eof  out  1  last pixel of the frame.
- busy  out  1  high while the state is not IDLE.
- frame_done  out  1  one-cycle pulse when the frame is complete.
- cfg_err  out  1  one-cycle pulse when a frame is rejected for a zero size.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, buffer count=0, x=y=0. All outputs read 0: fifo_rd_en, m_valid, m_data, m_x, m_y, all flags, busy, frame_done, cfg_err.
- FIFO pop rule: pop = fifo_rd_vld & fifo_rd_en.
  - fifo_rd_en = (state==RUN) & (count<2).
  - fifo_rd_en must never depend combinationally on fifo_rd_vld.
  - fifo_rd_en is 0 in IDLE and DRAIN; the block never pops beyond the frame size.
- State IDLE:
  - On frame_start, latch cfg_h_active and cfg_v_active.
  - If either size is 0: pulse cfg_err on the next cycle and stay in IDLE.
  - Otherwise: go to RUN with x=0, y=0.
- State RUN, on each pop:
  - Push {data, x, y, sof=(x==0&y==0), eol=(x==H-1), eof=(x==H-1&y==V-1)} into the output buffer.
  - If x==H-1: x=0 and y=y+1; otherwise x=x+1.
  - The pop carrying eof moves the state to DRAIN in the same edge.
- State DRAIN: when count reaches 0 (the eof beat has been accepted), pulse frame_done for exactly 1 cycle and return to IDLE. frame_done is high in the cycle after the eof handshake.
- frame_start outside IDLE is ignored. No error is flagged and the latched sizes are unchanged.
- Output buffer: 2-entry register FIFO.
  - m_valid = (count!=0); m_data and all tags come from the head entry.
  - Handshake: beat transfers when m_valid & m_ready. Head data and tags hold stable while m_valid=1 & m_ready=0.
  - Push and pop in the same cycle leave count unchanged and preserve order.
- Timing:
  - Latency: a pixel popped at edge N is on m_data after edge N (1 cycle).
  - Sustained throughput is 1 pixel/clk when fifo_rd_vld=1 and m_ready=1.
- Sizes: maximum is 2^H_W-1 by 2^V_W-1. The x counter never reaches H; the y counter never exceeds V-1.
- H=1: every pixel has eol=1.
- H=1, V=1: the single beat has sof=eol=eof=1.
- Reset mid-frame: returns to IDLE in 1 cycle. Buffered beats are discarded; FIFO contents are untouched.

Test Plan:
1. H=4, V=2; fifo_rd_vld=1 with pixels 0..7; m_ready=1 → 8 consecutive beats with m_x 0,1,2,3,0,1,2,3 and m_y 0×4,1×4. sof on beat 0, eol on beats 3 and 7, eof on beat 7. fifo_rd_en high for exactly 8 cycles. frame_done 1 cycle after beat 7; busy falls with it.
2. Same frame, m_ready=0 for cycles 2-6 → fifo_rd_en drops once count=2. m_data holds stable. Exactly 8 beats in order 0..7, with no duplicates or losses.
3. fifo_rd_vld toggling 1,0,1,0 → beats are gapped, coordinates stay correct, no extra pops, frame_done occurs once.
4. frame_start with cfg_h_active=0 (or cfg_v_active=0) → cfg_err pulses once, busy stays 0, fifo_rd_en stays 0.
5. H=1, V=1 with one pixel 0xABCDEF → single beat with sof=eol=eof=1 and x=y=0, followed by frame_done. A second frame_start mid-RUN of a longer frame is ignored.
6. rst asserted at pixel 5 of an H=4, V=2 frame, then a new frame_start → all outputs 0 and state IDLE after 1 cycle. The new frame starts at x=y=0 with sof set on its first beat.
